// File: rtl/dsram_arb_pkg.sv
// Shared types and helpers for the L1 data-SRAM port arbiter.
// Line/byte-enable widths, response source tag and way decode.
package dsram_arb_pkg;

  localparam int LINE_BITS = 256;
  localparam int BE_BITS   = 32;
  localparam int MAX_WAYS  = 256;

  typedef enum logic {
    SRC_LD = 1'b0,
    SRC_EV = 1'b1
  } rsp_src_e;

  function automatic logic [MAX_WAYS-1:0] onehot(
    input logic [7:0] way
  );
    onehot      = '0;
    onehot[way] = 1'b1;
  endfunction

endpackage

// File: rtl/dsram_prio_arb2.sv
// Two-input fixed-priority arbiter; the low-priority side
// carries a saturating starve counter that forces it through.
module dsram_prio_arb2 #(
  parameter int STARVE_MAX = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hi_req,
  input  logic lo_req,
  input  logic hold,
  output logic sel_lo,
  output logic hi_gnt,
  output logic lo_gnt
);

  logic [7:0] cnt;
  logic       force_lo;

  assign force_lo = lo_req && (cnt == 8'(STARVE_MAX));
  assign sel_lo   = lo_req && (!hi_req || force_lo);
  assign hi_gnt   = hi_req && !sel_lo && !hold;
  assign lo_gnt   = sel_lo && !hold;

  // Held-off winner still ages, so a hazard cannot starve it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!lo_req || lo_gnt) begin
      cnt <= '0;
    end else if (!force_lo) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dsram_port_arb.sv
// L1 data-SRAM read/write port arbiter with 1-cycle response capture.
// Define DSRAM_ARB_BYPASS_EN to forward same-way write bytes into reads.
module dsram_port_arb
  import dsram_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 13,
  parameter  int NUM_WAYS   = 4,
  parameter  int STARVE_MAX = 7,
  localparam int WAY_W      = $clog2(NUM_WAYS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_req,
  output logic                          ld_gnt,
  input  logic [ADDR_WIDTH-1:0]         ld_idx,
  input  logic [WAY_W-1:0]              ld_way,
  input  logic                          ev_req,
  output logic                          ev_gnt,
  input  logic [ADDR_WIDTH-1:0]         ev_idx,
  input  logic [WAY_W-1:0]              ev_way,
  input  logic                          st_req,
  output logic                          st_gnt,
  input  logic [ADDR_WIDTH-1:0]         st_idx,
  input  logic [WAY_W-1:0]              st_way,
  input  logic [BE_BITS-1:0]            st_be,
  input  logic [LINE_BITS-1:0]          st_wd,
  input  logic                          fl_req,
  output logic                          fl_gnt,
  input  logic [ADDR_WIDTH-1:0]         fl_idx,
  input  logic [WAY_W-1:0]              fl_way,
  input  logic [LINE_BITS-1:0]          fl_wd,
  output logic [ADDR_WIDTH-1:0]         ds_a,
  output logic [ADDR_WIDTH-1:0]         ds_aq,
  output logic [BE_BITS-1:0]            ds_be,
  output logic [LINE_BITS-1:0]          ds_wd,
  output logic [NUM_WAYS-1:0]           ds_read,
  output logic [NUM_WAYS-1:0]           ds_write,
  input  logic [NUM_WAYS*LINE_BITS-1:0] ds_rd,
  output logic                          rsp_valid,
  output logic                          rsp_src,
  output logic [LINE_BITS-1:0]          rsp_data
);

  logic ld_v, ev_v, st_v, fl_v;
  logic rd_any, wr_any, rd_hold;
  logic rd_sel_lo, wr_sel_lo;
  logic rd_gnt, wr_gnt;
  logic [ADDR_WIDTH-1:0] rd_idx, wr_idx;
  logic [ADDR_WIDTH-1:0] ds_a_q, ds_aq_q;
  logic [WAY_W-1:0] rd_way, wr_way, way_q;
  logic [LINE_BITS-1:0] rd_line;
  rsp_src_e src_q;

  assign ld_v = ld_req & rst_n;
  assign ev_v = ev_req & rst_n;
  assign st_v = st_req & rst_n;
  assign fl_v = fl_req & rst_n;

  assign rd_any = ld_v | ev_v;
  assign wr_any = st_v | fl_v;
  assign rd_idx = rd_sel_lo ? ld_idx : ev_idx;
  assign rd_way = rd_sel_lo ? ld_way : ev_way;
  assign wr_idx = wr_sel_lo ? st_idx : fl_idx;
  assign wr_way = wr_sel_lo ? st_way : fl_way;

`ifdef DSRAM_ARB_BYPASS_EN
  logic merge, merge_q;
  logic [BE_BITS-1:0] be_q;
  logic [LINE_BITS-1:0] wd_q;
  assign rd_hold = 1'b0;
  assign merge   = rd_any && wr_any && (rd_idx == wr_idx)
                && (rd_way == wr_way);
`else
  assign rd_hold = rd_any && wr_any && (rd_idx == wr_idx);
`endif

  dsram_prio_arb2 #(.STARVE_MAX(STARVE_MAX)) u_rd_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .hi_req (ev_v),
    .lo_req (ld_v),
    .hold   (rd_hold),
    .sel_lo (rd_sel_lo),
    .hi_gnt (ev_gnt),
    .lo_gnt (ld_gnt)
  );

  dsram_prio_arb2 #(.STARVE_MAX(STARVE_MAX)) u_wr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .hi_req (fl_v),
    .lo_req (st_v),
    .hold   (1'b0),
    .sel_lo (wr_sel_lo),
    .hi_gnt (fl_gnt),
    .lo_gnt (st_gnt)
  );

  assign rd_gnt = ld_gnt | ev_gnt;
  assign wr_gnt = st_gnt | fl_gnt;

  assign ds_a     = rd_gnt ? rd_idx : ds_a_q;
  assign ds_aq    = wr_gnt ? wr_idx : ds_aq_q;
  assign ds_read  = rd_gnt ? NUM_WAYS'(onehot(8'(rd_way))) : '0;
  assign ds_write = wr_gnt ? NUM_WAYS'(onehot(8'(wr_way))) : '0;

  always_comb begin
    ds_be = '0;
    ds_wd = '0;
    unique case (1'b1)
      fl_gnt: begin
        ds_be = '1;
        ds_wd = fl_wd;
      end
      st_gnt: begin
        ds_be = st_be;
        ds_wd = st_wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_a_q    <= '0;
      ds_aq_q   <= '0;
      rsp_valid <= 1'b0;
      src_q     <= SRC_LD;
      way_q     <= '0;
    end else begin
      ds_a_q    <= ds_a;
      ds_aq_q   <= ds_aq;
      rsp_valid <= rd_gnt;
      if (rd_gnt) begin
        src_q <= ld_gnt ? SRC_LD : SRC_EV;
        way_q <= rd_way;
      end
    end
  end

  assign rsp_src = src_q;
  assign rd_line = ds_rd[int'(way_q)*LINE_BITS +: LINE_BITS];

`ifdef DSRAM_ARB_BYPASS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_q <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
    end else begin
      merge_q <= merge;
      be_q    <= ds_be;
      wd_q    <= ds_wd;
    end
  end

  // Array returned pre-write data; overlay the bytes written alongside.
  always_comb begin
    rsp_data = rd_line;
    if (merge_q) begin
      for (int b = 0; b < BE_BITS; b++) begin
        if (be_q[b]) rsp_data[b*8 +: 8] = wd_q[b*8 +: 8];
      end
    end
  end
`else
  assign rsp_data = rd_line;
`endif

endmodule

// File: tb/tb_dsram_port_arb.sv
// Self-checking bench for dsram_port_arb with an SRAM array model
// and a response scoreboard.
module tb_dsram_port_arb;

  localparam int AW = 13;
  localparam int NW = 4;

  typedef struct packed {
    logic         src;
    logic [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ld_req, ld_gnt, ev_req, ev_gnt;
  logic st_req, st_gnt, fl_req, fl_gnt;
  logic [AW-1:0] ld_idx, ev_idx, st_idx, fl_idx;
  logic [1:0] ld_way, ev_way, st_way, fl_way;
  logic [31:0] st_be;
  logic [255:0] st_wd, fl_wd;
  logic [AW-1:0] ds_a, ds_aq;
  logic [31:0] ds_be;
  logic [255:0] ds_wd;
  logic [NW-1:0] ds_read, ds_write;
  logic [NW*256-1:0] ds_rd;
  logic rsp_valid, rsp_src;
  logic [255:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  logic [255:0] mem [int];
  logic [255:0] rd_q [NW];
  logic [255:0] mline;

  always #5 clk = ~clk;

  dsram_port_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_idx(ld_idx), .ld_way(ld_way),
    .ev_req(ev_req), .ev_gnt(ev_gnt), .ev_idx(ev_idx), .ev_way(ev_way),
    .st_req(st_req), .st_gnt(st_gnt), .st_idx(st_idx), .st_way(st_way),
    .st_be(st_be), .st_wd(st_wd),
    .fl_req(fl_req), .fl_gnt(fl_gnt), .fl_idx(fl_idx), .fl_way(fl_way),
    .fl_wd(fl_wd),
    .ds_a(ds_a), .ds_aq(ds_aq), .ds_be(ds_be), .ds_wd(ds_wd),
    .ds_read(ds_read), .ds_write(ds_write), .ds_rd(ds_rd),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_data(rsp_data)
  );

  function automatic logic [255:0] pat(input int w, input int idx);
    for (int k = 0; k < 8; k++)
      pat[k*32 +: 32] = {8'(w), 8'(k), 16'(idx)} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [255:0] fpat(input int w);
    for (int k = 0; k < 8; k++)
      fpat[k*32 +: 32] = {8'hF0 + 8'(w), 8'(k), 16'hBEEF};
  endfunction

  function automatic logic [255:0] bmerge(
    input logic [255:0] old, input logic [255:0] wd, input logic [31:0] be
  );
    bmerge = old;
    for (int b = 0; b < 32; b++)
      if (be[b]) bmerge[b*8 +: 8] = wd[b*8 +: 8];
  endfunction

  function automatic logic [255:0] rdmem(input int w, input int idx);
    int key;
    key = w * 8192 + idx;
    if (mem.exists(key)) rdmem = mem[key];
    else rdmem = pat(w, idx);
  endfunction

  // Data array model: 1-cycle read latency, read returns pre-write data.
  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (ds_read[w]) rd_q[w] <= rdmem(w, int'(ds_a));
      if (ds_write[w]) begin
        mline = bmerge(rdmem(w, int'(ds_aq)), ds_wd, ds_be);
        mem[w * 8192 + int'(ds_aq)] = mline;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NW; w++) ds_rd[w*256 +: 256] = rd_q[w];
  end

  // Response scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected src=%0d data=%h required=none",
                 rsp_src, rsp_data);
      end else begin
        e = q.pop_front();
        if ({rsp_src, rsp_data} !== e) begin
          n_fail++;
          $display("FAIL rsp got src=%0d data=%h required src=%0d data=%h",
                   rsp_src, rsp_data, e.src, e.data);
        end
      end
    end
  end

  task automatic clear_reqs();
    ld_req = 0; ev_req = 0; st_req = 0; fl_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_reqs();
    ld_idx = '0; ev_idx = '0; st_idx = '0; fl_idx = '0;
    ld_way = '0; ev_way = '0; st_way = '0; fl_way = '0;
    st_be = '0; st_wd = '0; fl_wd = '0;
    for (int w = 0; w < NW; w++) rd_q[w] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({rsp_valid, rsp_src, ds_a, ds_aq, ds_read, ds_write, ds_be,
         ld_gnt, ev_gnt, st_gnt, fl_gnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state v=%b s=%b a=%0d aq=%0d rd=%b wr=%b be=%h required all 0",
               rsp_valid, rsp_src, ds_a, ds_aq, ds_read, ds_write, ds_be);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_load_only();
    @(posedge clk); #1;
    ld_req = 1; ld_idx = 13'd5; ld_way = 2'd2;
    #1;
    n_tests++;
    if ({ld_gnt, ds_read, ds_a} !== {1'b1, 4'b0100, 13'd5}) begin
      n_fail++;
      $display("FAIL load_grant gnt=%b rd=%b a=%0d required 1 0100 5",
               ld_gnt, ds_read, ds_a);
    end
    q.push_back({1'b0, pat(2, 5)});
    @(posedge clk); #1;
    clear_reqs();
    #1;
    n_tests++;
    if ({rsp_valid, ds_a, ds_read, ds_be, ds_wd} !== {1'b1, 13'd5, 4'b0, 32'b0, 256'b0}) begin
      n_fail++;
      $display("FAIL idle_hold v=%b a=%0d rd=%b be=%h required 1 5 0000 0",
               rsp_valid, ds_a, ds_read, ds_be);
    end
    repeat (2) @(posedge clk);
  endtask

  // All four requesters pending: fill/evict win 7 cycles, store/load on 8th.
  task automatic test_starve(input string tag);
    logic [325:0] obs, exp;
    logic [255:0] sw, fw;
    logic [31:0] sb;
    sw = pat(7, 7); fw = pat(6, 6); sb = 32'h0F0F_00FF;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      ev_req = 1; ev_idx = 13'd20; ev_way = 2'd3;
      ld_req = 1; ld_idx = 13'd21; ld_way = 2'd1;
      fl_req = 1; fl_idx = 13'd3;  fl_way = 2'd1; fl_wd = fw;
      st_req = 1; st_idx = 13'd9;  st_way = 2'd0; st_be = sb; st_wd = sw;
      #1;
      if (k < 8)
        exp = {2'b10, 13'd20, 4'b1000, 2'b10, 13'd3, 4'b0010, 32'hFFFF_FFFF, fw};
      else
        exp = {2'b01, 13'd21, 4'b0010, 2'b01, 13'd9, 4'b0001, sb, sw};
      obs = {ev_gnt, ld_gnt, ds_a, ds_read, fl_gnt, st_gnt, ds_aq, ds_write, ds_be, ds_wd};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s_cycle%0d got=%h required=%h", tag, k, obs, exp);
      end
      if (k < 8) q.push_back({1'b1, pat(3, 20)});
      else       q.push_back({1'b0, pat(1, 21)});
    end
    @(posedge clk); #1;
    clear_reqs();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_collision();
    logic [255:0] cw;
    logic [31:0] cb;
    cw = fpat(9); cb = 32'h0000_F00F;
    @(posedge clk); #1;
    ld_req = 1; ld_idx = 13'd12; ld_way = 2'd2;
    st_req = 1; st_idx = 13'd12; st_way = 2'd2; st_be = cb; st_wd = cw;
    #1;
    n_tests++;
`ifdef DSRAM_ARB_BYPASS_EN
    if ({ld_gnt, st_gnt} !== 2'b11) begin
      n_fail++;
      $display("FAIL collide_bypass ld=%b st=%b required 1 1", ld_gnt, st_gnt);
    end
    q.push_back({1'b0, bmerge(pat(2, 12), cw, cb)});
    @(posedge clk); #1;
    clear_reqs();
`else
    if ({ld_gnt, st_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL collide_stall ld=%b st=%b required 0 1", ld_gnt, st_gnt);
    end
    @(posedge clk); #1;
    st_req = 0;
    #1;
    n_tests++;
    if (ld_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_retry ld=%b required 1", ld_gnt);
    end
    q.push_back({1'b0, bmerge(pat(2, 12), cw, cb)});
    @(posedge clk); #1;
    clear_reqs();
`endif
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ev_req = 1; ev_idx = 13'd20; ev_way = 2'd3;
    ld_req = 1; ld_idx = 13'd30; ld_way = 2'd0;
    fl_req = 1; fl_idx = 13'd3; fl_way = 2'd1;
    st_req = 1; st_idx = 13'd9; st_way = 2'd0;
    q.push_back({1'b1, pat(3, 20)});
    @(posedge clk); #1;
    ev_req = 0;
    #1;
    n_tests++;
    if (ld_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ld_grant ld=%b required 1", ld_gnt);
    end
    @(posedge clk); #1;
    rst_n = 0;
    clear_reqs();
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rsp_drop v=%b required 0", rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_rsp v=%b required 0", rsp_valid);
    end
    test_starve("post_reset");
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < NW; w++) begin
      @(posedge clk); #1;
      fl_req = 1; fl_idx = 13'd0; fl_way = 2'(w); fl_wd = fpat(w);
      #1;
      n_tests++;
      if ({fl_gnt, ds_write, ds_aq} !== {1'b1, 4'(1 << w), 13'd0}) begin
        n_fail++;
        $display("FAIL fill_way%0d gnt=%b wr=%b aq=%0d", w, fl_gnt, ds_write, ds_aq);
      end
    end
    for (int w = 0; w < NW; w++) begin
      @(posedge clk); #1;
      fl_req = 0;
      ld_req = 1; ld_idx = 13'd0; ld_way = 2'(w);
      #1;
      n_tests++;
      if ({ld_gnt, ds_read} !== {1'b1, 4'(1 << w)}) begin
        n_fail++;
        $display("FAIL readback_gnt%0d gnt=%b rd=%b", w, ld_gnt, ds_read);
      end
      if (w > 0) begin
        n_tests++;
        if (rsp_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL readback_b2b%0d v=%b required 1", w, rsp_valid);
        end
      end
      q.push_back({1'b0, fpat(w)});
    end
    @(posedge clk); #1;
    clear_reqs();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_starve("starve");
    test_collision();
    test_reset_mid();
    test_back_to_back();
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_missing got=%0d pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
